// File: rtl/load_data_align_pkg.sv
// load_data_align_pkg: opcode/funct3 constants and the per-load metadata carried across memory latency
package load_data_align_pkg;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [2:0] FNC_LB   = 3'd0;
    localparam logic [2:0] FNC_LH   = 3'd1;
    localparam logic [2:0] FNC_LW   = 3'd2;
    localparam logic [2:0] FNC_LBU  = 3'd4;
    localparam logic [2:0] FNC_LHU  = 3'd5;
    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] off;
        logic [4:0] rd;
    } meta_t;
endpackage

// File: rtl/load_data_align_if.sv
// load_data_align_if: issue, pipeline control, BRAM read word and aligned load result
interface load_data_align_if;
    logic        stall;
    logic        flush;
    logic        issue_valid;
    logic [6:0]  issue_opcode;
    logic [2:0]  issue_funct3;
    logic [1:0]  issue_addr_lo;
    logic [4:0]  issue_rd;
    logic [31:0] mem_rdata;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd;
    logic        ld_misalign;
    logic        ld_illegal;
    modport master (
        output stall, flush, issue_valid, issue_opcode, issue_funct3, issue_addr_lo, issue_rd, mem_rdata,
        input  ld_valid, ld_data, ld_rd, ld_misalign, ld_illegal
    );
    modport slave (
        input  stall, flush, issue_valid, issue_opcode, issue_funct3, issue_addr_lo, issue_rd, mem_rdata,
        output ld_valid, ld_data, ld_rd, ld_misalign, ld_illegal
    );
endinterface

// File: rtl/load_data_align_extract.sv
// load_extract: selects, aligns and extends the addressed bytes of a word; flags faults
module load_extract
    import load_data_align_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] data,
    output logic        misalign,
    output logic        illegal
);
    logic [15:0] h;
    always_comb begin
        h        = 16'(word >> {off, 3'b000});
        illegal  = !(funct3 inside {FNC_LB, FNC_LH, FNC_LW, FNC_LBU, FNC_LHU});
        misalign = ((funct3 == FNC_LH || funct3 == FNC_LHU) && off == 2'd3) || (funct3 == FNC_LW && off != 2'd0);
        data     = (illegal || misalign) ? 32'd0 :
                   funct3 == FNC_LB  ? {{24{h[7]}}, h[7:0]} :
                   funct3 == FNC_LBU ? {24'd0, h[7:0]} :
                   funct3 == FNC_LH  ? {{16{h[15]}}, h} :
                   funct3 == FNC_LHU ? {16'd0, h} : word;
    end
endmodule

// File: rtl/load_data_align.sv
// load_data_align: tracks in-flight loads across BRAM latency and delivers aligned writeback data
module load_data_align
    import load_data_align_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    load_data_align_if.slave bus
);
    meta_t                  meta [MEM_LATENCY];
    logic [MEM_LATENCY-1:0] vld;
    logic                   hold_vld;
    logic [31:0]            hold_data;
    logic [31:0]            data;
    logic                   accept;
    logic                   fin;
    logic                   out_vld;
    logic                   misalign;
    logic                   illegal;
    assign accept  = bus.issue_valid && bus.issue_opcode == OPC_LOAD && !bus.stall && !bus.flush;
    assign fin     = vld[MEM_LATENCY-1];
    assign out_vld = fin && rst_n && !bus.flush;
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            vld      <= '0;
            hold_vld <= 1'b0;
        end else if (!bus.stall) begin
            vld      <= MEM_LATENCY'({vld, accept});
            hold_vld <= 1'b0;
        end else if (fin) begin
            hold_vld <= 1'b1;
        end
    end
    // BRAM output is only trustworthy on the first stalled cycle, so capture it there
    always_ff @(posedge clk) begin
        if (!bus.stall) begin
            meta[0] <= {bus.issue_funct3, bus.issue_addr_lo, bus.issue_rd};
            for (int i = 1; i < MEM_LATENCY; i++) meta[i] <= meta[i-1];
        end
        if (fin && bus.stall && !hold_vld) hold_data <= bus.mem_rdata;
    end
    load_extract u_extract (
        .funct3   (meta[MEM_LATENCY-1].funct3),
        .off      (meta[MEM_LATENCY-1].off),
        .word     (hold_vld ? hold_data : bus.mem_rdata),
        .data     (data),
        .misalign (misalign),
        .illegal  (illegal)
    );
    assign bus.ld_valid    = out_vld;
    assign bus.ld_data     = out_vld ? data : 32'd0;
    assign bus.ld_rd       = out_vld ? meta[MEM_LATENCY-1].rd : 5'd0;
    assign bus.ld_misalign = out_vld && misalign;
    assign bus.ld_illegal  = out_vld && illegal;
endmodule

// File: tb/tb_load_data_align.sv
// tb_load_data_align: drives latency-1 and latency-2 instances in lockstep against a queue-based load model
module tb_load_data_align;
    import load_data_align_pkg::*;

    typedef struct {
        int          k;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [4:0]  rd;
        logic [31:0] w;
        int          rem;
    } ent_t;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  o;
        logic [31:0] w;
        logic [31:0] d;
        logic        m;
        logic        i;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] nword;
    logic        fresh;
    ent_t        q[$];
    int          checks;
    int          errors;

    load_data_align_if b0();
    load_data_align_if b1();

    load_data_align #(.MEM_LATENCY(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    load_data_align #(.MEM_LATENCY(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural load result: {data, misalign, illegal}
    function automatic logic [33:0] ref_load(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] w);
        longint v;
        int     sh;
        sh = 8 * int'(o);
        if (f3 == FNC_LB || f3 == FNC_LBU) begin
            v = (longint'(w) >> sh) % 256;
            if (f3 == FNC_LB && v >= 128) v = v - 256;
            return {32'(v), 2'b00};
        end
        if (f3 == FNC_LH || f3 == FNC_LHU) begin
            if (o == 2'd3) return {32'd0, 2'b10};
            v = (longint'(w) >> sh) % 65536;
            if (f3 == FNC_LH && v >= 32768) v = v - 65536;
            return {32'(v), 2'b00};
        end
        if (f3 == FNC_LW) return (o == 2'd0) ? {w, 2'b00} : {32'd0, 2'b10};
        return {32'd0, 2'b01};
    endfunction

    function automatic logic [39:0] expv(input int k);
        logic [33:0] r;
        if (!rst_n || b0.flush) return 40'd0;
        foreach (q[i]) if (q[i].k == k && q[i].rem == 0) begin
            r = ref_load(q[i].f3, q[i].off, q[i].w);
            return {1'b1, r[33:2], q[i].rd, r[1:0]};
        end
        return 40'd0;
    endfunction

    function automatic logic [39:0] obs(input int k);
        return k == 0 ? {b0.ld_valid, b0.ld_data, b0.ld_rd, b0.ld_misalign, b0.ld_illegal}
                      : {b1.ld_valid, b1.ld_data, b1.ld_rd, b1.ld_misalign, b1.ld_illegal};
    endfunction

    // Apply one cycle of stimulus; the BRAM model returns a word only in its first valid cycle
    task automatic drive(input logic r, input logic s, input logic f, input logic v, input logic [6:0] op,
                         input logic [2:0] fn, input logic [1:0] a, input logic [4:0] d, input logic [31:0] w);
        logic [31:0] md [2];
        rst_n = r;
        nword = w;
        b0.stall = s;          b1.stall = s;
        b0.flush = f;          b1.flush = f;
        b0.issue_valid = v;    b1.issue_valid = v;
        b0.issue_opcode = op;  b1.issue_opcode = op;
        b0.issue_funct3 = fn;  b1.issue_funct3 = fn;
        b0.issue_addr_lo = a;  b1.issue_addr_lo = a;
        b0.issue_rd = d;       b1.issue_rd = d;
        for (int k = 0; k < 2; k++) begin
            md[k] = $urandom;
            foreach (q[i]) if (q[i].k == k && q[i].rem == 0 && fresh) md[k] = q[i].w;
        end
        b0.mem_rdata = md[0];
        b1.mem_rdata = md[1];
        #1;
    endtask

    task automatic adv();
        ent_t nq[$];
        ent_t e;
        @(posedge clk);
        if (!rst_n || b0.flush) begin
            q.delete();
        end else if (!b0.stall) begin
            foreach (q[i]) if (q[i].rem > 0) begin
                e = q[i];
                e.rem--;
                nq.push_back(e);
            end
            if (b0.issue_valid && b0.issue_opcode == OPC_LOAD)
                for (int k = 0; k < 2; k++)
                    nq.push_back('{k, b0.issue_funct3, b0.issue_addr_lo, b0.issue_rd, nword, k});
            q = nq;
        end
        fresh = !b0.stall;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 0, 1, OPC_LOAD, FNC_LW, 0, 5'd1, 32'h1);
            adv();
        end
        drive(1, 0, 0, 0, 7'd0, 3'd0, 2'd0, 5'd0, 32'd0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs(k) !== 40'd0) begin
                errors++;
                $display("FAIL reset dut%0d got=%h exp=%h", k, obs(k), 40'd0);
            end
        end
        adv();
    endtask

    task automatic test_extract();
        vec_t tv[8];
        tv = '{'{FNC_LB,  2'd3, 32'h80123456, 32'hFFFFFF80, 1'b0, 1'b0},
               '{FNC_LBU, 2'd3, 32'h80123456, 32'h00000080, 1'b0, 1'b0},
               '{FNC_LH,  2'd1, 32'h00ABCD00, 32'hFFFFABCD, 1'b0, 1'b0},
               '{FNC_LHU, 2'd2, 32'h90000000, 32'h00009000, 1'b0, 1'b0},
               '{FNC_LW,  2'd2, 32'h12345678, 32'h00000000, 1'b1, 1'b0},
               '{FNC_LH,  2'd3, 32'h12345678, 32'h00000000, 1'b1, 1'b0},
               '{3'd3,    2'd0, 32'h12345678, 32'h00000000, 1'b0, 1'b1},
               '{FNC_LW,  2'd0, 32'h12345678, 32'h12345678, 1'b0, 1'b0}};
        foreach (tv[t]) begin
            drive(1, 0, 0, 1, OPC_LOAD, tv[t].f3, tv[t].o, 5'(t + 3), tv[t].w);
            adv();
            for (int c = 1; c <= 2; c++) begin
                drive(1, 0, 0, 0, 7'd0, 3'd0, 2'd0, 5'd0, 32'd0);
                checks++;
                if (obs(c - 1) !== {1'b1, tv[t].d, 5'(t + 3), tv[t].m, tv[t].i}) begin
                    errors++;
                    $display("FAIL extract vec%0d dut%0d got=%h exp=%h", t, c - 1, obs(c - 1),
                             {1'b1, tv[t].d, 5'(t + 3), tv[t].m, tv[t].i});
                end
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (obs(k) !== expv(k)) begin
                        errors++;
                        $display("FAIL extract_model vec%0d dut%0d got=%h exp=%h", t, k, obs(k), expv(k));
                    end
                end
                adv();
            end
        end
    endtask

    task automatic test_stall_hold();
        int cons;
        cons = 0;
        drive(1, 0, 0, 1, OPC_LOAD, FNC_LW, 2'd0, 5'd9, 32'hCAFEF00D);
        adv();
        for (int c = 1; c <= 7; c++) begin
            drive(1, c <= 3, 0, 0, 7'd0, 3'd0, 2'd0, 5'd0, 32'd0);
            if (b0.ld_valid && !b0.stall) cons++;
            if (c <= 4) begin
                checks++;
                if (b0.ld_data !== 32'hCAFEF00D || b0.ld_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_hold cyc%0d got=%h/%b exp=cafef00d/1", c, b0.ld_data, b0.ld_valid);
                end
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL stall_model cyc%0d dut%0d got=%h exp=%h", c, k, obs(k), expv(k));
                end
            end
            adv();
        end
        checks++;
        if (cons != 1) begin
            errors++;
            $display("FAIL stall_consume got=%0d exp=1", cons);
        end
    endtask

    task automatic test_flush();
        drive(1, 0, 0, 1, OPC_LOAD, FNC_LW, 2'd0, 5'd4, 32'h11112222);
        adv();
        for (int c = 1; c <= 8; c++) begin
            drive(1, 0, c == 1 || c == 5, c == 5, OPC_LOAD, FNC_LB, 2'd1, 5'd6, 32'h33334444);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== 40'd0 || obs(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL flush cyc%0d dut%0d got=%h exp=%h", c, k, obs(k), expv(k));
                end
            end
            b0.issue_valid = 1'b0;
            b1.issue_valid = 1'b0;
            adv();
        end
    endtask

    task automatic test_reset_inflight();
        drive(1, 0, 0, 1, OPC_LOAD, FNC_LW, 2'd0, 5'd7, 32'hDEADBEEF);
        adv();
        for (int c = 1; c <= 4; c++) begin
            drive(c != 1, 0, 0, 0, 7'd0, 3'd0, 2'd0, 5'd0, 32'd0);
            b0.mem_rdata = 32'hDEADBEEF;
            b1.mem_rdata = 32'hDEADBEEF;
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== 40'd0) begin
                    errors++;
                    $display("FAIL reset_inflight cyc%0d dut%0d got=%h exp=%h", c, k, obs(k), 40'd0);
                end
            end
            adv();
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 7; c++) begin
            drive(1, 0, 0, c < 4, OPC_LOAD, FNC_LW, 2'd0, 5'(c + 10), $urandom);
            checks++;
            if (b0.ld_valid !== (c >= 1 && c <= 4)) begin
                errors++;
                $display("FAIL b2b_valid cyc%0d got=%b exp=%b", c, b0.ld_valid, c >= 1 && c <= 4);
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL b2b cyc%0d dut%0d got=%h exp=%h", c, k, obs(k), expv(k));
                end
            end
            adv();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(49) != 0, $urandom_range(3) == 0, $urandom_range(9) == 0,
                  $urandom_range(3) != 0, $urandom_range(7) != 0 ? OPC_LOAD : 7'($urandom),
                  3'($urandom), 2'($urandom), 5'($urandom), $urandom);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs(k) !== expv(k)) begin
                    errors++;
                    $display("FAIL random cyc%0d dut%0d got=%h exp=%h", c, k, obs(k), expv(k));
                end
            end
            adv();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        fresh  = 1'b0;
        test_reset();
        test_extract();
        test_stall_hold();
        test_flush();
        test_reset_inflight();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
